life_monitor: RTL and testbench

- Downstream observer of the toroidal N×N life array; samples the full `cells` vector on every clk edge, one sample per generation.
- Tracks the generation index and registered population.
- Classifies the run as extinct, still life, period-2 oscillator, or generation-limit reached, then freezes its outputs.
- Consumed by the top-level controller and display logic to decide when to reseed, which is done by pulsing nrst to the array.

---
 rtl/life_pkg.sv | 24 ++
 rtl/life_popcount.sv | 25 ++
 rtl/life_monitor.sv | 117 +++++++++++
 tb/tb_life_monitor.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared definitions for the life-array monitor: status codes, FSM states,
// and the population width helper.
`timescale 1ns/1ps
package life_pkg;

   localparam logic [2:0] ST_RUNNING = 3'd0;
   localparam logic [2:0] ST_DEAD    = 3'd1;
   localparam logic [2:0] ST_STILL   = 3'd2;
   localparam logic [2:0] ST_OSC2    = 3'd3;
   localparam logic [2:0] ST_LIMIT   = 3'd4;

   typedef enum logic [1:0] {
      PRIME0 = 2'd0,
      PRIME1 = 2'd1,
      RUN    = 2'd2,
      TERM   = 2'd3
   } state_t;

   // Bits needed to hold a live-cell count of 0 .. n*n inclusive.
   function automatic int pop_w(input int n);
      return $clog2(n * n + 1);
   endfunction

endpackage

// File: rtl/life_popcount.sv
// Combinational population count of a W-bit vector, built as a balanced
// binary adder tree over the vector padded to a power-of-two width.
`timescale 1ns/1ps
module life_popcount #(
   parameter int W  = 16,
   parameter int PW = 5
) (
   input  logic [W-1:0]  vec,
   output logic [PW-1:0] count
);

   localparam int P = (W <= 1) ? 1 : (1 << $clog2(W));

   // Heap-ordered tree: leaves at P-1 .. 2P-2, node k sums children 2k+1 and 2k+2.
   always_comb begin
      logic [PW-1:0] node [0:2*P-2];
      for (int k = 0; k < 2 * P - 1; k++) node[k] = '0;
      for (int k = 0; k < P; k++) begin
         if (k < W) node[P-1+k] = PW'(vec[k]);
      end
      for (int k = P - 2; k >= 0; k--) node[k] = node[2*k+1] + node[2*k+2];
      count = node[0];
   end

endmodule

// File: rtl/life_monitor.sv
// Observer of the toroidal life array: counts generations and population and
// classifies the run as extinct, still life, period-2 oscillator or limit hit,
// after which every output is frozen until clear or reset.
`timescale 1ns/1ps
module life_monitor
   import life_pkg::*;
#(
   parameter int  N       = 4,
   parameter int  GEN_W   = 16,
   parameter int  MAX_GEN = 1000,
   localparam int PW      = pop_w(N)
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic [N*N-1:0]   cells,
   input  logic             clear,
   output logic [PW-1:0]    population,
   output logic [GEN_W-1:0] generation,
   output logic [2:0]       status,
   output logic             done
);

   state_t           state, state_nxt;
   logic [N*N-1:0]   snap1, snap2, snap1_nxt, snap2_nxt;
   logic [PW-1:0]    pop_now, pop_nxt;
   logic [GEN_W-1:0] gen_nxt;
   logic [2:0]       status_nxt;

   life_popcount #(.W(N*N), .PW(PW)) u_pop (
      .vec   (cells),
      .count (pop_now)
   );

   // Next-state: clear wins over everything; TERM holds; otherwise take a sample and classify.
   always_comb begin
      state_nxt  = state;
      snap1_nxt  = snap1;
      snap2_nxt  = snap2;
      pop_nxt    = population;
      gen_nxt    = generation;
      status_nxt = status;
      if (clear) begin
         state_nxt  = PRIME0;
         snap1_nxt  = '0;
         snap2_nxt  = '0;
         pop_nxt    = '0;
         gen_nxt    = '0;
         status_nxt = ST_RUNNING;
      end else if (state != TERM) begin
         snap2_nxt = snap1;
         snap1_nxt = cells;
         pop_nxt   = pop_now;
         case (state)
            PRIME0: begin
               gen_nxt = '0;
               if (cells == '0) begin
                  state_nxt  = TERM;
                  status_nxt = ST_DEAD;
               end else begin
                  state_nxt = PRIME1;
               end
            end
            PRIME1: begin
               gen_nxt = GEN_W'(1);
               if (cells == '0) begin
                  state_nxt  = TERM;
                  status_nxt = ST_DEAD;
               end else if (cells == snap1) begin
                  state_nxt  = TERM;
                  status_nxt = ST_STILL;
               end else begin
                  state_nxt = RUN;
               end
            end
            default: begin
               // RUN: snap2 holds a real sample here, so period-2 is checkable.
               gen_nxt = generation + GEN_W'(1);
               if (cells == '0) begin
                  state_nxt  = TERM;
                  status_nxt = ST_DEAD;
               end else if (cells == snap1) begin
                  state_nxt  = TERM;
                  status_nxt = ST_STILL;
               end else if (cells == snap2) begin
                  state_nxt  = TERM;
                  status_nxt = ST_OSC2;
               end else if (gen_nxt == GEN_W'(MAX_GEN)) begin
                  state_nxt  = TERM;
                  status_nxt = ST_LIMIT;
               end
            end
         endcase
      end
   end

   // State and output registers with asynchronous return to the idle values.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state      <= PRIME0;
         snap1      <= '0;
         snap2      <= '0;
         population <= '0;
         generation <= '0;
         status     <= ST_RUNNING;
      end else begin
         state      <= state_nxt;
         snap1      <= snap1_nxt;
         snap2      <= snap2_nxt;
         population <= pop_nxt;
         generation <= gen_nxt;
         status     <= status_nxt;
      end
   end

   assign done = (status != ST_RUNNING);

endmodule

// File: tb/tb_life_monitor.sv
// Bench for life_monitor (N=4, MAX_GEN=8): directed scenarios plus a random
// run compared against a history-based reference model.
`timescale 1ns/1ps
module tb_life_monitor;

   localparam int N       = 4;
   localparam int GEN_W   = 16;
   localparam int MAX_GEN = 8;
   localparam int PW      = 5;

   logic             clk = 1'b0;
   logic             nrst;
   logic [N*N-1:0]   cells;
   logic             clear;
   logic [PW-1:0]    population;
   logic [GEN_W-1:0] generation;
   logic [2:0]       status;
   logic             done;

   int total = 0;
   int bad   = 0;

   // Reference model: the list of samples since the last restart.
   logic [15:0]      m_hist[$];
   logic [2:0]       m_status;
   logic [PW-1:0]    m_pop;
   logic [GEN_W-1:0] m_gen;

   always #5 clk = ~clk;

   life_monitor #(.N(N), .GEN_W(GEN_W), .MAX_GEN(MAX_GEN)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .cells      (cells),
      .clear      (clear),
      .population (population),
      .generation (generation),
      .status     (status),
      .done       (done)
   );

   task automatic step(input logic [15:0] c, input logic clr);
      cells = c;
      clear = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic model_restart();
      m_hist.delete();
      m_status = 3'd0;
      m_pop    = '0;
      m_gen    = '0;
   endtask

   // One generation: the k-th sample since restart has index k; compare with
   // the previous one and the one before, and stop at the generation limit.
   task automatic model_edge(input logic [15:0] c, input logic clr);
      int k;
      if (clr) begin
         model_restart();
         return;
      end
      if (m_status != 3'd0) return;
      k     = m_hist.size();
      m_gen = GEN_W'(k);
      m_pop = PW'($countones(c));
      if (c == 16'h0)                        m_status = 3'd1;
      else if (k >= 1 && c == m_hist[k-1])   m_status = 3'd2;
      else if (k >= 2 && c == m_hist[k-2])   m_status = 3'd3;
      else if (k == MAX_GEN)                 m_status = 3'd4;
      m_hist.push_back(c);
   endtask

   task automatic test_reset();
      nrst = 1'b0; clear = 1'b0; cells = 16'hFFFF;
      repeat (3) @(posedge clk);
      #1;
      total++; if (population !== '0) begin bad++; $display("FAIL reset_pop got=%0d want=0", population); end
      total++; if (generation !== '0) begin bad++; $display("FAIL reset_gen got=%0d want=0", generation); end
      total++; if (status !== 3'd0)   begin bad++; $display("FAIL reset_status got=%0d want=0", status); end
      total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done got=%0d want=0", done); end
      nrst = 1'b1;
      step(16'h0000, 1'b0);
      total++; if (status !== 3'd1)   begin bad++; $display("FAIL dead_status got=%0d want=1", status); end
      total++; if (done !== 1'b1)     begin bad++; $display("FAIL dead_done got=%0d want=1", done); end
      total++; if (generation !== 0)  begin bad++; $display("FAIL dead_gen got=%0d want=0", generation); end
      total++; if (population !== 0)  begin bad++; $display("FAIL dead_pop got=%0d want=0", population); end
   endtask

   task automatic test_still();
      step(16'h0000, 1'b1);
      step(16'h0033, 1'b0);
      total++; if (status !== 3'd0)   begin bad++; $display("FAIL still_e0_status got=%0d want=0", status); end
      total++; if (population !== 4)  begin bad++; $display("FAIL still_e0_pop got=%0d want=4", population); end
      step(16'h0033, 1'b0);
      total++; if (status !== 3'd2)   begin bad++; $display("FAIL still_status got=%0d want=2", status); end
      total++; if (generation !== 1)  begin bad++; $display("FAIL still_gen got=%0d want=1", generation); end
      total++; if (done !== 1'b1)     begin bad++; $display("FAIL still_done got=%0d want=1", done); end
      repeat (5) step(16'h1234, 1'b0);
      total++; if (status !== 3'd2 || generation !== 1 || population !== 4) begin
         bad++; $display("FAIL still_frozen got=%0d/%0d/%0d want=2/1/4", status, generation, population);
      end
   endtask

   task automatic test_clear_term();
      step(16'h0033, 1'b1);
      total++; if (status !== 3'd0 || generation !== 0 || population !== 0 || done !== 1'b0) begin
         bad++; $display("FAIL clear_term got=%0d/%0d/%0d want=0/0/0", status, generation, population);
      end
      step(16'h0033, 1'b0);
      total++; if (status !== 3'd0)   begin bad++; $display("FAIL clear_rerun0 got=%0d want=0", status); end
      step(16'h0033, 1'b0);
      total++; if (status !== 3'd2 || generation !== 1) begin
         bad++; $display("FAIL clear_redetect got=%0d/%0d want=2/1", status, generation);
      end
   endtask

   task automatic test_clear_detect();
      step(16'h0000, 1'b1);
      step(16'h0033, 1'b0);
      step(16'h0000, 1'b1);
      total++; if (status !== 3'd0 || generation !== 0 || population !== 0) begin
         bad++; $display("FAIL clear_prio got=%0d/%0d/%0d want=0/0/0", status, generation, population);
      end
      step(16'h0000, 1'b0);
      total++; if (status !== 3'd1 || generation !== 0) begin
         bad++; $display("FAIL clear_prio_after got=%0d/%0d want=1/0", status, generation);
      end
   endtask

   task automatic test_blinker();
      step(16'h0000, 1'b1);
      step(16'h0070, 1'b0);
      step(16'h0222, 1'b0);
      total++; if (status !== 3'd0 || generation !== 1) begin
         bad++; $display("FAIL blink_e1 got=%0d/%0d want=0/1", status, generation);
      end
      step(16'h0070, 1'b0);
      total++; if (status !== 3'd3)   begin bad++; $display("FAIL blink_status got=%0d want=3", status); end
      total++; if (generation !== 2)  begin bad++; $display("FAIL blink_gen got=%0d want=2", generation); end
      total++; if (population !== 3)  begin bad++; $display("FAIL blink_pop got=%0d want=3", population); end
   endtask

   task automatic test_limit();
      step(16'h0000, 1'b1);
      for (int k = 0; k < 8; k++) begin
         step(16'(k + 1), 1'b0);
         total++; if (status !== 3'd0 || generation !== GEN_W'(k)) begin
            bad++; $display("FAIL limit_run%0d got=%0d/%0d want=0/%0d", k, status, generation, k);
         end
      end
      step(16'd9, 1'b0);
      total++; if (status !== 3'd4 || generation !== 8 || population !== 2) begin
         bad++; $display("FAIL limit_hit got=%0d/%0d/%0d want=4/8/2", status, generation, population);
      end
   endtask

   task automatic test_async_reset();
      step(16'h0000, 1'b1);
      for (int k = 0; k < 6; k++) step(16'(16'h0100 + k), 1'b0);
      total++; if (generation !== 5 || status !== 3'd0) begin
         bad++; $display("FAIL arst_pre got=%0d/%0d want=5/0", generation, status);
      end
      #3 nrst = 1'b0;
      #1;
      total++; if (generation !== 0 || population !== 0 || status !== 3'd0 || done !== 1'b0) begin
         bad++; $display("FAIL arst_now got=%0d/%0d/%0d want=0/0/0", generation, population, status);
      end
      #2 nrst = 1'b1;
      step(16'h0033, 1'b0);
      total++; if (status !== 3'd0 || generation !== 0 || population !== 4) begin
         bad++; $display("FAIL arst_prime0 got=%0d/%0d/%0d want=0/0/4", status, generation, population);
      end
   endtask

   task automatic test_random();
      logic [15:0] prev1, prev2, c;
      logic        clr;
      prev1 = 16'h0; prev2 = 16'h0;
      step(16'h0000, 1'b1);
      model_restart();
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 5))
            0:       c = prev1;
            1, 2:    c = prev2;
            3:       c = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'(1 << $urandom_range(0, 15));
            default: c = 16'($urandom);
         endcase
         if (m_status != 3'd0) clr = ($urandom_range(0, 2) == 0);
         else                  clr = ($urandom_range(0, 30) == 0);
         model_edge(c, clr);
         step(c, clr);
         prev2 = prev1; prev1 = c;
         total++; if (status !== m_status || generation !== m_gen || population !== m_pop || done !== (m_status != 3'd0)) begin
            bad++;
            $display("FAIL rand%0d got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d", i, status, generation, population, done, m_status, m_gen, m_pop);
         end
      end
   endtask

   initial begin
      nrst = 1'b0; clear = 1'b0; cells = 16'hFFFF;
      test_reset();
      test_still();
      test_clear_term();
      test_clear_detect();
      test_blinker();
      test_limit();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
